// File: rtl/imem_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words and writes them
// sequentially into instruction memory, holding the core in reset for the whole load.
module imem_loader #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int unsigned              MAX_WORDS     = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [15:0]              len_words,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     mem_wr_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     cpu_rst,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

  state_e                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [15:0]             word_idx_q, word_idx_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0]   buf_q, buf_d;
  logic                    err_q, err_d;
  logic                    len_ok;
  logic                    last_word;

  assign len_ok    = (len_words != 16'd0) && (32'(len_words) <= MAX_WORDS);
  assign last_word = (word_idx_q == len_q - 16'd1);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    buf_d      = buf_q;
    err_d      = err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (len_ok) begin
            len_d      = len_words;
            word_idx_d = '0;
            byte_idx_d = '0;
            err_d      = 1'b0;
            state_d    = StRecv;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRecv: begin
        if (byte_valid) begin
          buf_d[{byte_idx_q, 3'b000} +: 8] = byte_in;
          byte_idx_d                       = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (last_word) begin
          state_d = StDone;
        end else begin
          word_idx_d = word_idx_q + 16'd1;
          byte_idx_d = '0;
          state_d    = StRecv;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      buf_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      buf_q      <= buf_d;
      err_q      <= err_d;
    end
  end

  // Address and data buses are forced to zero outside the write strobe.
  always_comb begin
    byte_ready = (state_q == StRecv);
    mem_wr_en  = (state_q == StWrite);
    mem_addr   = '0;
    mem_wdata  = '0;
    if (mem_wr_en) begin
      mem_addr  = BASE_ADDR + ADDRESS_WIDTH'({word_idx_q, 2'b00});
      mem_wdata = buf_q;
    end
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    cpu_rst = rst | busy;
    err     = err_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized loads compared against a
// byte-stream model of the expected instruction-memory writes and their timing.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          MAXW = 256;

  typedef logic [7:0] bytes_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len_words = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, mem_wr_en, cpu_rst, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int idle_bus_cnt = 0;
  int          wr_cyc[$];
  int          acc_cyc[$];
  int          done_cyc[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .BASE_ADDR    (BASE),
    .MAX_WORDS    (MAXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len_words (len_words),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (byte_valid && byte_ready) acc_cyc.push_back(cyc);
    if (done) done_cyc.push_back(cyc);
    if (busy && !byte_ready && !mem_wr_en && !done) stall_cnt <= stall_cnt + 1;
    if (!mem_wr_en && (mem_addr != 0 || mem_wdata != 0)) idle_bus_cnt <= idle_bus_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference: word k is bytes 4k..4k+3, least significant byte first.
  function automatic logic [31:0] model_word(input bytes_t b, input int k);
    return {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
  endfunction

  task automatic clear_mon();
    wr_cyc.delete();
    acc_cyc.delete();
    done_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] len);
    start     = 1'b1;
    len_words = len;
    tick();
    start     = 1'b0;
    len_words = 16'($urandom);
  endtask

  // mode 0: back-to-back, 1: valid low every other cycle, 2: random gaps
  task automatic send(input bytes_t b, input int mode, output bit ok);
    int i = 0;
    int g = 0;
    bit ph = 1'b0;
    while (i < b.size() && g < 10 * b.size() + 20) begin
      if ((mode == 1 && ph) || (mode == 2 && $urandom_range(3) == 0)) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_in    = b[i];
      end
      ph = !ph;
      @(negedge clk);
      if (byte_valid && byte_ready) i++;
      tick();
      g++;
    end
    byte_valid = 1'b0;
    ok = (i == b.size());
  endtask

  task automatic wait_done(output bit ok);
    bit seen;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      seen = done;
      tick();
      if (seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_load(input logic [15:0] len, input bytes_t b, input int mode, output bit ok);
    bit ok_s, ok_d;
    do_start(len);
    send(b, mode, ok_s);
    wait_done(ok_d);
    ok = ok_s && ok_d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst);
    end
    checks++;
    if ({byte_ready, mem_wr_en, busy, done, err} !== 5'b0 || mem_addr !== 0 || mem_wdata !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b wr=%b busy=%b done=%b err=%b addr=%h data=%h want 0",
               byte_ready, mem_wr_en, busy, done, err, mem_addr, mem_wdata);
    end
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({cpu_rst, byte_ready, busy} !== 3'b0) begin
      errors++;
      $display("FAIL reset_release: got cpu_rst=%b rdy=%b busy=%b want 0 0 0",
               cpu_rst, byte_ready, busy);
    end
    tick();
  endtask

  task automatic test_directed();
    bytes_t b = '{8'h93, 8'h05, 8'h10, 8'h00, 8'h13, 8'h06, 8'hF0, 8'h0F};
    bit ok;
    clear_mon();
    do_load(16'd2, b, 0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL directed_complete: got ok=%b want 1", ok);
    end
    @(negedge clk);
    checks++;
    if ({cpu_rst, busy, byte_ready} !== 3'b0) begin
      errors++;
      $display("FAIL directed_release: got cpu_rst=%b busy=%b rdy=%b want 0", cpu_rst, busy,
               byte_ready);
    end
    tick();
    checks++;
    if (wr_addr.size() !== 2 || done_cyc.size() !== 1 || acc_cyc.size() !== 8) begin
      errors++;
      $display("FAIL directed_counts: got writes=%0d dones=%0d bytes=%0d want 2 1 8",
               wr_addr.size(), done_cyc.size(), acc_cyc.size());
    end else begin
      checks++;
      if (wr_addr[0] !== BASE || wr_data[0] !== 32'h0010_0593) begin
        errors++;
        $display("FAIL directed_word0: got %h/%h want %h/00100593", wr_addr[0], wr_data[0], BASE);
      end
      checks++;
      if (wr_addr[1] !== BASE + 32'd4 || wr_data[1] !== 32'h0FF0_0613) begin
        errors++;
        $display("FAIL directed_word1: got %h/%h want %h/0ff00613", wr_addr[1], wr_data[1],
                 BASE + 32'd4);
      end
      checks++;
      if (wr_cyc[0] !== acc_cyc[3] + 1 || wr_cyc[1] !== acc_cyc[7] + 1) begin
        errors++;
        $display("FAIL directed_wr_timing: got %0d,%0d want %0d,%0d", wr_cyc[0], wr_cyc[1],
                 acc_cyc[3] + 1, acc_cyc[7] + 1);
      end
      checks++;
      if (done_cyc[0] !== wr_cyc[1] + 1) begin
        errors++;
        $display("FAIL directed_done_timing: got %0d want %0d", done_cyc[0], wr_cyc[1] + 1);
      end
      checks++;
      if (wr_cyc[1] - acc_cyc[0] + 1 !== 10) begin
        errors++;
        $display("FAIL directed_span: got %0d want 10", wr_cyc[1] - acc_cyc[0] + 1);
      end
    end
  endtask

  task automatic test_gaps();
    bytes_t b = '{8'h93, 8'h05, 8'h10, 8'h00, 8'h13, 8'h06, 8'hF0, 8'h0F};
    bit ok;
    int stall0;
    clear_mon();
    stall0 = stall_cnt;
    do_load(16'd2, b, 1, ok);
    tick();
    checks++;
    if (!ok || wr_addr.size() !== 2 || acc_cyc.size() !== 8 || done_cyc.size() !== 1) begin
      errors++;
      $display("FAIL gaps_counts: got ok=%b writes=%0d bytes=%0d dones=%0d want 1 2 8 1", ok,
               wr_addr.size(), acc_cyc.size(), done_cyc.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (wr_addr[k] !== BASE + 32'(4 * k) || wr_data[k] !== model_word(b, k)) begin
          errors++;
          $display("FAIL gaps_word%0d: got %h/%h want %h/%h", k, wr_addr[k], wr_data[k],
                   BASE + 32'(4 * k), model_word(b, k));
        end
      end
    end
    checks++;
    if (stall_cnt !== stall0) begin
      errors++;
      $display("FAIL gaps_ready_held: got %0d not-ready busy cycles want 0", stall_cnt - stall0);
    end
  endtask

  task automatic test_reject();
    bytes_t b;
    bit ok;
    clear_mon();
    do_start(16'd0);
    @(negedge clk);
    checks++;
    if ({err, busy, byte_ready} !== 3'b100) begin
      errors++;
      $display("FAIL reject_len0: got err=%b busy=%b rdy=%b want 1 0 0", err, busy, byte_ready);
    end
    tick();
    do_start(16'(MAXW + 1));
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({err, busy, cpu_rst} !== 3'b100) begin
      errors++;
      $display("FAIL reject_lenmax: got err=%b busy=%b cpu_rst=%b want 1 0 0", err, busy, cpu_rst);
    end
    tick();
    checks++;
    if (wr_addr.size() !== 0) begin
      errors++;
      $display("FAIL reject_no_write: got %0d writes want 0", wr_addr.size());
    end
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    do_start(16'd1);
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reject_err_clear: got err=%b want 0", err);
    end
    tick();
    send(b, 0, ok);
    wait_done(ok);
    tick();
    checks++;
    if (!ok || wr_addr.size() !== 1 || wr_data[0] !== model_word(b, 0)) begin
      errors++;
      $display("FAIL reject_then_load: got ok=%b writes=%0d want 1 1", ok, wr_addr.size());
    end
  endtask

  task automatic test_rst_mid();
    bytes_t b;
    bytes_t b2 = '{8'h13, 8'h00, 8'h00, 8'h00};
    bit ok;
    clear_mon();
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    do_start(16'd2);
    send(b, 0, ok);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_cpu_rst: got %b want 1", cpu_rst);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, byte_ready, err, cpu_rst} !== 4'b0) begin
      errors++;
      $display("FAIL rstmid_idle: got busy=%b rdy=%b err=%b cpu_rst=%b want 0", busy, byte_ready,
               err, cpu_rst);
    end
    tick();
    checks++;
    if (!ok || wr_addr.size() !== 1 || wr_data[0] !== model_word(b, 0)) begin
      errors++;
      $display("FAIL rstmid_partial: got ok=%b writes=%0d want 1 1", ok, wr_addr.size());
    end
    clear_mon();
    do_load(16'd1, b2, 0, ok);
    tick();
    checks++;
    if (!ok || wr_addr.size() !== 1 || done_cyc.size() !== 1) begin
      errors++;
      $display("FAIL rstmid_reload_counts: got ok=%b writes=%0d dones=%0d want 1 1 1", ok,
               wr_addr.size(), done_cyc.size());
    end else begin
      checks++;
      if (wr_addr[0] !== BASE || wr_data[0] !== 32'h0000_0013) begin
        errors++;
        $display("FAIL rstmid_reload_word: got %h/%h want %h/00000013", wr_addr[0], wr_data[0],
                 BASE);
      end
    end
  endtask

  task automatic test_start_ignored();
    bytes_t b;
    bytes_t lo;
    bytes_t hi;
    bit ok;
    clear_mon();
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    lo = b[0:1];
    hi = b[2:3];
    do_start(16'd1);
    send(lo, 0, ok);
    start     = 1'b1;
    len_words = 16'd5;
    tick();
    start = 1'b0;
    send(hi, 0, ok);
    wait_done(ok);
    repeat (5) tick();
    checks++;
    if (!ok || wr_addr.size() !== 1 || done_cyc.size() !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_counts: got ok=%b writes=%0d dones=%0d busy=%b want 1 1 1 0",
               ok, wr_addr.size(), done_cyc.size(), busy);
    end else begin
      checks++;
      if (wr_data[0] !== model_word(b, 0) || wr_addr[0] !== BASE) begin
        errors++;
        $display("FAIL ignored_start_word: got %h/%h want %h/%h", wr_addr[0], wr_data[0], BASE,
                 model_word(b, 0));
      end
    end
  endtask

  task automatic test_random();
    int idle0;
    idle0 = idle_bus_cnt;
    for (int it = 0; it < 6; it++) begin
      bytes_t b;
      bit ok;
      int n;
      int bad;
      n = (it == 5) ? MAXW : int'($urandom_range(1, 6));
      for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
      clear_mon();
      do_load(16'(n), b, (it == 5) ? 0 : 2, ok);
      tick();
      checks++;
      if (!ok || wr_addr.size() !== n || done_cyc.size() !== 1 || acc_cyc.size() !== 4 * n) begin
        errors++;
        $display("FAIL random_counts it%0d: got ok=%b writes=%0d dones=%0d want 1 %0d 1", it, ok,
                 wr_addr.size(), done_cyc.size(), n);
        continue;
      end
      bad = 0;
      for (int k = 0; k < n; k++) begin
        if (wr_addr[k] !== BASE + 32'(4 * k) || wr_data[k] !== model_word(b, k) ||
            wr_cyc[k] !== acc_cyc[4 * k + 3] + 1) begin
          if (bad == 0)
            $display("FAIL random_word it%0d k%0d: got %h/%h@%0d want %h/%h@%0d", it, k,
                     wr_addr[k], wr_data[k], wr_cyc[k], BASE + 32'(4 * k), model_word(b, k),
                     acc_cyc[4 * k + 3] + 1);
          bad++;
        end
      end
      checks++;
      if (bad != 0) errors++;
      checks++;
      if (done_cyc[0] !== wr_cyc[n - 1] + 1) begin
        errors++;
        $display("FAIL random_done it%0d: got %0d want %0d", it, done_cyc[0], wr_cyc[n - 1] + 1);
      end
      if (it == 5) begin
        checks++;
        if (wr_cyc[n - 1] - acc_cyc[0] + 1 !== 5 * n) begin
          errors++;
          $display("FAIL random_max_span: got %0d want %0d", wr_cyc[n - 1] - acc_cyc[0] + 1, 5 * n);
        end
      end
    end
    checks++;
    if (idle_bus_cnt !== idle0) begin
      errors++;
      $display("FAIL random_idle_bus: got %0d nonzero idle cycles want 0", idle_bus_cnt - idle0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_gaps();
    test_reject();
    test_rst_mid();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the single-cycle RISC-V core: accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words and writes them sequentially into the instruction memory write port. The core's PC fetch path is the reader of instruction memory; this block is the writer. It holds the core in reset for the whole load and releases it once the last word is committed.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, width of instruction memory byte address
- DATA_WIDTH, 32, instruction word width (fixed at 32; four bytes per word)
- BASE_ADDR, 32'h0, byte address of first written word
- MAX_WORDS, 256, largest accepted program length

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin load; sampled only in IDLE
- len_words  input  16  program length in words, latched on accepted start
- byte_in  input  8  stream byte
- byte_valid  input  1  byte_in valid
- byte_ready  output  1  loader accepts a byte this cycle
- mem_wr_en  output  1  instruction memory write strobe
- mem_addr  output  ADDRESS_WIDTH  write byte address (word aligned)
- mem_wdata  output  DATA_WIDTH  write data
- cpu_rst  output  1  reset to core; high while loading
- busy  output  1  high in RECV, WRITE, DONE
- done  output  1  one-cycle pulse, load complete
- err  output  1  sticky: last start rejected

## Operation
- States: IDLE, RECV, WRITE, DONE. Registers: len (16b), word_idx (16b), byte_idx (2b), word buffer (32b).
- IDLE: byte_ready=0. On start: if 1 <= len_words <= MAX_WORDS, latch len, clear word_idx/byte_idx/err, go RECV; else set err=1, stay IDLE, no write.
- RECV: byte_ready=1. Transfer when byte_valid && byte_ready: buffer[8*byte_idx +: 8] <= byte_in, byte_idx++. Transfer with byte_idx==3 -> WRITE. No transfer -> hold.
- WRITE: byte_ready=0, mem_wr_en=1 for exactly this cycle, mem_addr = BASE_ADDR + 4*word_idx, mem_wdata = buffer. If word_idx == len-1 -> DONE, else word_idx++, byte_idx=0, -> RECV.
- DONE: done=1 for one cycle, -> IDLE.
- start outside IDLE ignored; len_words ignored except on accepted start.
- mem_addr/mem_wdata are don't-care while mem_wr_en=0 (drive 0).
- cpu_rst = rst | busy.
- rst in any state: -> IDLE, counters and buffer cleared, err cleared; a partially assembled word is discarded, words already written stay in memory.

## Timing
- Reset values (cycle rst high): byte_ready=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, cpu_rst=1.
- Accepted start at edge E0 -> RECV from E0; byte_ready high in the following cycle.
- Back-to-back bytes: one byte per cycle; 4 RECV cycles + 1 WRITE cycle per word; minimum 5*N cycles from first byte to last write for N words.
- Write of word k occurs in the cycle immediately after its 4th byte is accepted.
- done asserts the cycle after the last WRITE; cpu_rst and busy fall the cycle after done.
- err updates the cycle after a rejected start and holds until next accepted start or rst.

## Test plan
- Reset: rst high 2 cycles -> cpu_rst=1, all other outputs 0; after release with no start, cpu_rst=0, byte_ready=0.
- len_words=2, start, bytes 93 05 10 00 13 06 F0 0F on consecutive cycles -> write addr 0x0 data 0x00100593 one cycle after byte 4, write addr 0x4 data 0x0FF00613 one cycle after byte 8, done one cycle later, cpu_rst low next cycle; exactly 2 mem_wr_en pulses.
- Same stream with byte_valid low every other cycle -> identical writes, byte_ready stays 1 through gaps, no extra or duplicated bytes.
- len_words=0, then len_words=MAX_WORDS+1 -> err=1 each time, no mem_wr_en, busy=0; subsequent valid start with len 1 clears err.
- rst after 6 bytes of a 2-word load -> only word 0 written; IDLE next cycle; new load len=1 bytes 13 00 00 00 -> write addr BASE_ADDR data 0x00000013.
- start pulsed with len_words=5 during an active len=1 load -> ignored; exactly one write, done once.
